// File: rtl/comportas_pwm_n_pkg.sv
// comportas_pkg: shared types and width helpers for the multi-gate servo controller.
//   estado_t   per-gate FSM state (FECHADA, ABRINDO, ABERTA, FECHANDO)
//   bits_cont  register width for a counter spanning 0..n-1 (never below 1)
//   bits_larg  register width able to hold a pulse width up to the PWM period
package comportas_pkg;

    typedef enum logic [1:0] {
        FECHADA  = 2'b00,
        ABRINDO  = 2'b01,
        ABERTA   = 2'b10,
        FECHANDO = 2'b11
    } estado_t;

    function automatic int bits_cont(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int bits_larg(input int periodo);
        return $clog2(periodo + 1);
    endfunction

endpackage

// File: rtl/comportas_pwm_n_if.sv
// comportas_pwm_n_if: command/status bundle between gate logic and the servo controller.
//   abrir       per-gate open request (1 = toward open, 0 = toward closed)
//   pausa       global hold of all gate motion
//   pwm         per-gate servo pulse
//   aberta      gate fully open
//   fechada     gate fully closed
//   movendo     gate in motion
//   db_posicao  packed positions, gate i at [i*POS_W +: POS_W]
//   master drives commands, slave (the controller) drives status.
interface comportas_pwm_n_if #(
    parameter int N_CANAIS = 2,
    parameter int POS_W    = 3
);
    logic [N_CANAIS-1:0]       abrir;
    logic                      pausa;
    logic [N_CANAIS-1:0]       pwm;
    logic [N_CANAIS-1:0]       aberta;
    logic [N_CANAIS-1:0]       fechada;
    logic [N_CANAIS-1:0]       movendo;
    logic [N_CANAIS*POS_W-1:0] db_posicao;

    modport master (output abrir, pausa, input pwm, aberta, fechada, movendo, db_posicao);
    modport slave  (input abrir, pausa, output pwm, aberta, fechada, movendo, db_posicao);
endinterface

// File: rtl/comportas_pwm_n_canal.sv
// comporta_canal: one gate - open/close FSM, position ramp, pulse-width latch and PWM compare.
//   clock, reset   system clock, asynchronous active-high reset
//   i_abrir        open request for this gate
//   i_pausa        global hold, suppresses steps
//   i_tick         shared step-interval tick
//   i_cnt_pwm      shared PWM period counter
//   o_pwm          registered servo pulse
//   o_aberta, o_fechada, o_movendo  status decoded from the registered state
//   o_pos          current position
module comporta_canal
    import comportas_pkg::*;
#(
    parameter int POS_W         = 3,
    parameter int POS_MAX       = 4,
    parameter int LARGURA_MIN   = 50_000,
    parameter int LARGURA_PASSO = 12_500,
    parameter int LW            = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_abrir,
    input  logic             i_pausa,
    input  logic             i_tick,
    input  logic [LW-1:0]    i_cnt_pwm,
    output logic             o_pwm,
    output logic             o_aberta,
    output logic             o_fechada,
    output logic             o_movendo,
    output logic [POS_W-1:0] o_pos
);
    estado_t          r_estado;
    logic [POS_W-1:0] r_pos;
    logic [LW-1:0]    r_largura;
    logic             r_pwm;
    logic             w_passo;
    logic [LW-1:0]    w_largura;

    assign w_passo = i_tick && !i_pausa;
    // The width reloads at the period start and is used in that same compare,
    // so every period carries exactly one width and never glitches mid-period.
    assign w_largura = (i_cnt_pwm == '0) ? LW'(LARGURA_MIN) + LW'(r_pos) * LW'(LARGURA_PASSO) : r_largura;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado  <= FECHADA;
            r_pos     <= '0;
            r_largura <= LW'(LARGURA_MIN);
            r_pwm     <= 1'b0;
        end else begin
            r_largura <= w_largura;
            r_pwm     <= (i_cnt_pwm < w_largura);
            // A reversal is checked first so it swallows a coincident step.
            // End-of-travel tests use >= / <= so a reversal at an end stop saturates.
            case (r_estado)
                FECHADA:  if (i_abrir) r_estado <= ABRINDO;
                ABRINDO:  if (!i_abrir) r_estado <= FECHANDO;
                          else if (w_passo) begin
                              if (r_pos >= POS_W'(POS_MAX - 1)) begin
                                  r_pos    <= POS_W'(POS_MAX);
                                  r_estado <= ABERTA;
                              end else r_pos <= r_pos + POS_W'(1);
                          end
                ABERTA:   if (!i_abrir) r_estado <= FECHANDO;
                FECHANDO: if (i_abrir) r_estado <= ABRINDO;
                          else if (w_passo) begin
                              if (r_pos <= POS_W'(1)) begin
                                  r_pos    <= '0;
                                  r_estado <= FECHADA;
                              end else r_pos <= r_pos - POS_W'(1);
                          end
                default:  r_estado <= FECHADA;
            endcase
        end
    end

    assign o_pwm     = r_pwm;
    assign o_aberta  = (r_estado == ABERTA);
    assign o_fechada = (r_estado == FECHADA);
    assign o_movendo = (r_estado == ABRINDO) || (r_estado == FECHANDO);
    assign o_pos     = r_pos;
endmodule

// File: rtl/comportas_pwm_n.sv
// comportas_pwm_n: N independent servo gates sharing one step timer and one PWM period counter.
//   clock, reset   system clock, asynchronous active-high reset
//   bus (slave)    abrir/pausa in; pwm, aberta, fechada, movendo, db_posicao out
module comportas_pwm_n
    import comportas_pkg::*;
#(
    parameter int N_CANAIS      = 2,
    parameter int POS_W         = 3,
    parameter int POS_MAX       = 4,
    parameter int INTERVALO     = 50_000_000,
    parameter int PERIODO_PWM   = 1_000_000,
    parameter int LARGURA_MIN   = 50_000,
    parameter int LARGURA_PASSO = 12_500
) (
    input logic               clock,
    input logic               reset,
    comportas_pwm_n_if.slave  bus
);
    localparam int IW = bits_cont(INTERVALO);
    localparam int LW = bits_larg(PERIODO_PWM);

    logic [IW-1:0]             r_intervalo;
    logic [LW-1:0]             r_cnt_pwm;
    logic                      w_tick;
    logic                      w_algum;
    logic [N_CANAIS-1:0]       w_pwm;
    logic [N_CANAIS-1:0]       w_aberta;
    logic [N_CANAIS-1:0]       w_fechada;
    logic [N_CANAIS-1:0]       w_movendo;
    logic [N_CANAIS*POS_W-1:0] w_pos;

    if (N_CANAIS < 1) begin : g_chk_n
        $error("comportas_pwm_n: N_CANAIS must be at least 1");
    end
    if (POS_MAX < 1 || POS_MAX >= 2 ** POS_W) begin : g_chk_pos
        $error("comportas_pwm_n: POS_MAX must lie in 1..2**POS_W-1");
    end
    if (INTERVALO < 1 || PERIODO_PWM < 1) begin : g_chk_per
        $error("comportas_pwm_n: INTERVALO and PERIODO_PWM must be positive");
    end
    if (LARGURA_MIN + POS_MAX * LARGURA_PASSO > PERIODO_PWM) begin : g_chk_larg
        $error("comportas_pwm_n: widest pulse exceeds PWM period");
    end

    assign w_algum = |w_movendo;
    assign w_tick  = (r_intervalo == IW'(INTERVALO - 1));

    // The step timer sits at 0 while every gate is idle, so a lone gate
    // always sees its first step a full interval after it starts moving.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_intervalo <= '0;
            r_cnt_pwm   <= '0;
        end else begin
            r_cnt_pwm   <= (r_cnt_pwm == LW'(PERIODO_PWM - 1)) ? '0 : r_cnt_pwm + LW'(1);
            r_intervalo <= !w_algum ? '0 : bus.pausa ? r_intervalo : w_tick ? '0 : r_intervalo + IW'(1);
        end
    end

    for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
        comporta_canal #(
            .POS_W        (POS_W),
            .POS_MAX      (POS_MAX),
            .LARGURA_MIN  (LARGURA_MIN),
            .LARGURA_PASSO(LARGURA_PASSO),
            .LW           (LW)
        ) u_canal (
            .clock    (clock),
            .reset    (reset),
            .i_abrir  (bus.abrir[i]),
            .i_pausa  (bus.pausa),
            .i_tick   (w_tick),
            .i_cnt_pwm(r_cnt_pwm),
            .o_pwm    (w_pwm[i]),
            .o_aberta (w_aberta[i]),
            .o_fechada(w_fechada[i]),
            .o_movendo(w_movendo[i]),
            .o_pos    (w_pos[i*POS_W +: POS_W])
        );
    end

    assign bus.pwm        = w_pwm;
    assign bus.aberta     = w_aberta;
    assign bus.fechada    = w_fechada;
    assign bus.movendo    = w_movendo;
    assign bus.db_posicao = w_pos;
endmodule

// File: tb/tb_comportas_pwm_n.sv
// tb_comportas_pwm_n: directed and random checks of comportas_pwm_n against a target/direction model.
module tb_comportas_pwm_n;
    localparam int N    = 2;
    localparam int PW   = 3;
    localparam int PMAX = 4;
    localparam int INT  = 4;
    localparam int PER  = 20;
    localparam int LMIN = 2;
    localparam int LP   = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    comportas_pwm_n_if #(.N_CANAIS(N), .POS_W(PW)) bus ();

    comportas_pwm_n #(
        .N_CANAIS     (N),
        .POS_W        (PW),
        .POS_MAX      (PMAX),
        .INTERVALO    (INT),
        .PERIODO_PWM  (PER),
        .LARGURA_MIN  (LMIN),
        .LARGURA_PASSO(LP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_ok  = 0;
    // Model: each gate has a position and a direction of travel (0 = at rest).
    int m_pos [N];
    int m_dir [N];
    int m_wid [N];
    int m_int;
    int m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_ok++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic m_reset();
        for (int c = 0; c < N; c++) begin
            m_pos[c] = 0;
            m_dir[c] = 0;
            m_wid[c] = LMIN;
        end
        m_int = 0;
        m_cnt = 0;
    endtask

    logic [N-1:0] m_pwm = '0;

    task automatic modelo();
        bit mov;
        bit tick;
        int want;
        int tgt;
        int nw;
        mov = 0;
        for (int c = 0; c < N; c++) mov |= (m_dir[c] != 0);
        tick = (m_int == INT - 1);
        for (int c = 0; c < N; c++) begin
            nw = (m_cnt == 0) ? LMIN + m_pos[c] * LP : m_wid[c];
            m_pwm[c] = (m_cnt < nw);
            m_wid[c] = nw;
            want = bus.abrir[c] ? 1 : -1;
            tgt  = bus.abrir[c] ? PMAX : 0;
            if (m_dir[c] == 0) begin
                if (m_pos[c] != tgt) m_dir[c] = want;
            end else if (m_dir[c] != want) begin
                m_dir[c] = want;
            end else if (tick && !bus.pausa) begin
                m_pos[c] = m_pos[c] + m_dir[c];
                if (m_pos[c] < 0) m_pos[c] = 0;
                if (m_pos[c] > PMAX) m_pos[c] = PMAX;
                if (m_pos[c] == tgt) m_dir[c] = 0;
            end
        end
        m_int = !mov ? 0 : bus.pausa ? m_int : (m_int + 1) % INT;
        m_cnt = (m_cnt + 1) % PER;
    endtask

    task automatic confere();
        logic [N-1:0]    ea, ef, em;
        logic [N*PW-1:0] ep;
        for (int c = 0; c < N; c++) begin
            ef[c] = (m_dir[c] == 0) && (m_pos[c] == 0);
            ea[c] = (m_dir[c] == 0) && (m_pos[c] == PMAX);
            em[c] = (m_dir[c] != 0);
            ep[c*PW +: PW] = PW'(m_pos[c]);
        end
        check("fechada", 32'(bus.fechada), 32'(ef));
        check("aberta", 32'(bus.aberta), 32'(ea));
        check("movendo", 32'(bus.movendo), 32'(em));
        check("posicao", 32'(bus.db_posicao), 32'(ep));
        check("pwm", 32'(bus.pwm), 32'(m_pwm));
    endtask

    task automatic step();
        @(posedge clock);
        modelo();
        #1;
        confere();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic conta(input int n, output int h);
        h = 0;
        repeat (n) begin
            step();
            h += int'(bus.pwm[0]);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pwm"}, 32'(bus.pwm), 32'd0);
        check({tag, "_aberta"}, 32'(bus.aberta), 32'd0);
        check({tag, "_fechada"}, 32'(bus.fechada), 32'd3);
        check({tag, "_movendo"}, 32'(bus.movendo), 32'd0);
        check({tag, "_pos"}, 32'(bus.db_posicao), 32'd0);
    endtask

    int h;
    logic [N*PW-1:0] p_hold;

    initial begin
        bus.abrir = '0;
        bus.pausa = 1'b0;
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset("rst");
        #3 reset = 1'b0;
        conta(40, h);
        check("idle_pwm_highs", 32'(h), 32'd4);
        bus.abrir = 2'b01;
        step();
        check("abrindo_c1", 32'(bus.movendo[0]), 32'd1);
        run(4);
        check("pos_c5", 32'(bus.db_posicao[2:0]), 32'd1);
        run(11);
        check("pos_c16", 32'(bus.db_posicao[2:0]), 32'd3);
        check("aberta_c16", 32'(bus.aberta[0]), 32'd0);
        step();
        check("pos_c17", 32'(bus.db_posicao[2:0]), 32'd4);
        check("aberta_c17", 32'(bus.aberta[0]), 32'd1);
        run(21);
        conta(40, h);
        check("open_pwm_highs", 32'(h), 32'd28);
        bus.abrir = 2'b00;
        step();
        check("fechando_c1", 32'(bus.movendo[0]), 32'd1);
        run(15);
        check("fechada_c16", 32'(bus.fechada[0]), 32'd0);
        step();
        check("fechada_c17", 32'(bus.fechada[0]), 32'd1);
        check("ch1_idle", 32'(bus.fechada[1]), 32'd1);
        bus.abrir = 2'b01;
        run(12);
        check("rev_pos_tick", 32'(bus.db_posicao[2:0]), 32'd2);
        bus.abrir = 2'b00;
        step();
        check("rev_pos_hold", 32'(bus.db_posicao[2:0]), 32'd2);
        check("rev_movendo", 32'(bus.movendo[0]), 32'd1);
        run(4);
        check("rev_pos_dec", 32'(bus.db_posicao[2:0]), 32'd1);
        run(4);
        check("rev_fechada", 32'(bus.fechada[0]), 32'd1);
        bus.abrir = 2'b11;
        run(6);
        p_hold = bus.db_posicao;
        bus.pausa = 1'b1;
        run(10);
        check("pausa_pos", 32'(bus.db_posicao), 32'(p_hold));
        bus.pausa = 1'b0;
        run(30);
        check("pausa_aberta", 32'(bus.aberta), 32'd3);
        bus.abrir = 2'b00;
        run(30);
        check("both_fechada", 32'(bus.fechada), 32'd3);
        bus.abrir = 2'b01;
        run(13);
        check("mid_pos3", 32'(bus.db_posicao[2:0]), 32'd3);
        #2 reset = 1'b1;
        #1;
        m_reset();
        m_pwm = '0;
        check_reset("async");
        #2 reset = 1'b0;
        run(17);
        check("reopen_pos", 32'(bus.db_posicao[2:0]), 32'd4);
        check("reopen_aberta", 32'(bus.aberta[0]), 32'd1);
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 15) == 0) bus.abrir = 2'($urandom);
            bus.pausa = ($urandom_range(0, 9) == 0);
            step();
        end
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
